// File: rtl/esm_pkg.sv
// Shared definitions for the ESM dependency tracker: slot lifecycle states,
// RISC-V register field positions and a width helper for index vectors.
package esm_pkg;

  typedef enum logic [1:0] {
    SLOT_FREE    = 2'd0,
    SLOT_PENDING = 2'd1,
    SLOT_ISSUED  = 2'd2
  } slot_state_e;

  localparam int unsigned RD_LSB  = 7;
  localparam int unsigned RS1_LSB = 15;
  localparam int unsigned RS2_LSB = 20;
  localparam int unsigned FIELD_W = 5;

  // Ceiling log2, used for slot and register index widths.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/esm_prio_enc.sv
// Lowest-set-bit priority encoder; picks the lowest free slot for insertion.
module esm_prio_enc #(
  parameter int unsigned N = 16,
  parameter int unsigned W = 4
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         found
);

  // Scanning downward lets the lowest requesting index win.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/esm_dep_tracker.sv
// Slot-based RAW/WAW dependency tracker feeding the ESM issue selector:
// per-slot lifecycle, BS x BS dependency matrix and a last-writer table.
module esm_dep_tracker
  import esm_pkg::*;
#(
  parameter int unsigned IW     = 32,
  parameter int unsigned BS     = 16,
  parameter int unsigned REGNUM = 16,
  parameter bit          WAW_EN = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  input  logic [IW-1:0]         ins_instr,
  input  logic                  ins_regwrite,
  input  logic                  ins_use_rs2,
  output logic [clog2(BS)-1:0]  ins_slot,
  output logic [0:BS-1]         ready_mask,
  input  logic [0:BS-1]         issue_mask,
  input  logic [0:BS-1]         complete_mask,
  output logic [clog2(BS):0]    occupancy
);

  localparam int unsigned SW = clog2(BS);
  localparam int unsigned RA = clog2(REGNUM);
  localparam int unsigned CW = SW + 1;

  slot_state_e       state      [BS];
  logic [BS-1:0]     dep        [BS];
  logic              prod_valid [REGNUM];
  logic [SW-1:0]     prod_slot  [REGNUM];

  logic [BS-1:0]     free_v;
  logic [BS-1:0]     iss_go;
  logic [BS-1:0]     cpl_go;
  logic [BS-1:0]     new_row;
  logic [CW-1:0]     cpl_cnt;
  logic [RA-1:0]     rd;
  logic [RA-1:0]     rs1;
  logic [RA-1:0]     rs2;
  logic              ins_fire;
  logic              unused_instr;

  assign rd  = ins_instr[RD_LSB  +: RA];
  assign rs1 = ins_instr[RS1_LSB +: RA];
  assign rs2 = ins_instr[RS2_LSB +: RA];
  assign unused_instr = ^ins_instr;

  // Legal handshake bits only: issue needs PENDING, complete needs ISSUED.
  always_comb begin
    free_v  = '0;
    iss_go  = '0;
    cpl_go  = '0;
    cpl_cnt = '0;
    for (int i = 0; i < int'(BS); i++) begin
      free_v[i] = (state[i] == SLOT_FREE);
      iss_go[i] = issue_mask[i] && (state[i] == SLOT_PENDING);
      cpl_go[i] = complete_mask[i] && (state[i] == SLOT_ISSUED);
      cpl_cnt   = cpl_cnt + CW'(cpl_go[i]);
    end
  end

  esm_prio_enc #(
    .N (BS),
    .W (SW)
  ) u_free_enc (
    .req   (free_v),
    .idx   (ins_slot),
    .found (ins_ready)
  );

  assign ins_fire = ins_valid && ins_ready;

  // Row for the incoming instruction; producers completing now are bypassed.
  always_comb begin
    new_row = '0;
    if ((rs1 != '0) && prod_valid[rs1]) begin
      new_row[prod_slot[rs1]] = 1'b1;
    end
    if (ins_use_rs2 && (rs2 != '0) && prod_valid[rs2]) begin
      new_row[prod_slot[rs2]] = 1'b1;
    end
    if (WAW_EN && ins_regwrite && (rd != '0) && prod_valid[rd]) begin
      new_row[prod_slot[rd]] = 1'b1;
    end
    new_row = new_row & ~cpl_go;
  end

  always_comb begin
    ready_mask = '0;
    for (int i = 0; i < int'(BS); i++) begin
      ready_mask[i] = (state[i] == SLOT_PENDING) && (dep[i] == '0);
    end
  end

  // Slot lifecycle, matrix and producer table; inserts are applied last so
  // their table write wins over a same-cycle completion clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(BS); i++) begin
        state[i] <= SLOT_FREE;
        dep[i]   <= '0;
      end
      for (int r = 0; r < int'(REGNUM); r++) begin
        prod_valid[r] <= 1'b0;
        prod_slot[r]  <= '0;
      end
      occupancy <= '0;
    end else if (flush) begin
      for (int i = 0; i < int'(BS); i++) begin
        state[i] <= SLOT_FREE;
        dep[i]   <= '0;
      end
      for (int r = 0; r < int'(REGNUM); r++) begin
        prod_valid[r] <= 1'b0;
        prod_slot[r]  <= '0;
      end
      occupancy <= '0;
    end else begin
      for (int i = 0; i < int'(BS); i++) begin
        case (state[i])
          SLOT_PENDING: if (iss_go[i]) state[i] <= SLOT_ISSUED;
          SLOT_ISSUED:  if (cpl_go[i]) state[i] <= SLOT_FREE;
          default: ;
        endcase
        dep[i] <= dep[i] & ~cpl_go;
      end
      for (int r = 0; r < int'(REGNUM); r++) begin
        if (prod_valid[r] && cpl_go[prod_slot[r]]) begin
          prod_valid[r] <= 1'b0;
        end
      end
      if (ins_fire) begin
        state[ins_slot] <= SLOT_PENDING;
        dep[ins_slot]   <= new_row;
        if (ins_regwrite && (rd != '0)) begin
          prod_valid[rd] <= 1'b1;
          prod_slot[rd]  <= ins_slot;
        end
      end
      occupancy <= occupancy + CW'(ins_fire) - cpl_cnt;
    end
  end

endmodule

// File: tb/tb_esm_dep_tracker.sv
// Bench for esm_dep_tracker: directed scenarios plus random traffic, with a
// RAW-only and a WAW-enabled instance checked against a tag-based model.
module tb_esm_dep_tracker;

  localparam int BS = 16;
  localparam int REGNUM = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        ins_valid;
  logic [31:0] ins_instr;
  logic        ins_regwrite;
  logic        ins_use_rs2;
  logic [0:15] issue_mask;
  logic [0:15] complete_mask;

  logic        ins_ready_n, ins_ready_w;
  logic [3:0]  ins_slot_n, ins_slot_w;
  logic [0:15] ready_mask_n, ready_mask_w;
  logic [4:0]  occ_n, occ_w;

  esm_dep_tracker #(.IW(32), .BS(BS), .REGNUM(REGNUM), .WAW_EN(1'b0)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .ins_valid(ins_valid),
    .ins_ready(ins_ready_n), .ins_instr(ins_instr), .ins_regwrite(ins_regwrite),
    .ins_use_rs2(ins_use_rs2), .ins_slot(ins_slot_n), .ready_mask(ready_mask_n),
    .issue_mask(issue_mask), .complete_mask(complete_mask), .occupancy(occ_n)
  );

  esm_dep_tracker #(.IW(32), .BS(BS), .REGNUM(REGNUM), .WAW_EN(1'b1)) u_waw (
    .clk(clk), .rst(rst), .flush(flush), .ins_valid(ins_valid),
    .ins_ready(ins_ready_w), .ins_instr(ins_instr), .ins_regwrite(ins_regwrite),
    .ins_use_rs2(ins_use_rs2), .ins_slot(ins_slot_w), .ready_mask(ready_mask_w),
    .issue_mask(issue_mask), .complete_mask(complete_mask), .occupancy(occ_w)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: each insert gets a unique tag; a dependency is open until that tag completes.
  int st      [16];   // 0 free, 1 pending, 2 issued
  int tag     [16];
  int dep_tag [16][3]; // rs1, rs2, rd(WAW) producer tags, -1 for none
  int prod    [16];
  bit done    [int];
  int next_tag = 0;

  task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit open_tag(input int t);
    return (t >= 0) && !done.exists(t);
  endfunction

  function automatic bit model_ready(input int i, input bit waw);
    if (st[i] != 1) return 1'b0;
    if (open_tag(dep_tag[i][0]) || open_tag(dep_tag[i][1])) return 1'b0;
    if (waw && open_tag(dep_tag[i][2])) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      st[i] = 0;
      tag[i] = -1;
      for (int k = 0; k < 3; k++) dep_tag[i][k] = -1;
      prod[i] = -1;
    end
  endtask

  function automatic int live_producer(input int r);
    if (r == 0) return -1;
    if (open_tag(prod[r])) return prod[r];
    return -1;
  endfunction

  task automatic model_update(input bit v, input logic [31:0] instr, input bit rw,
                              input bit u2, input logic [0:15] iss,
                              input logic [0:15] cpl, input bit fl);
    int s, r1, r2, rdn;
    if (fl) begin
      model_reset();
      return;
    end
    s = -1;
    for (int i = 15; i >= 0; i--) if (st[i] == 0) s = i;
    for (int i = 0; i < 16; i++) begin
      if (st[i] == 1 && iss[i]) st[i] = 2;
      else if (st[i] == 2 && cpl[i]) begin
        st[i] = 0;
        done[tag[i]] = 1'b1;
      end
    end
    if (v && s >= 0) begin
      rdn = int'(instr[11:7]) % REGNUM;
      r1  = int'(instr[19:15]) % REGNUM;
      r2  = int'(instr[24:20]) % REGNUM;
      dep_tag[s][0] = live_producer(r1);
      dep_tag[s][1] = u2 ? live_producer(r2) : -1;
      dep_tag[s][2] = rw ? live_producer(rdn) : -1;
      st[s]  = 1;
      tag[s] = next_tag;
      next_tag++;
      if (rw && rdn != 0) prod[rdn] = tag[s];
    end
  endtask

  task automatic check_outputs();
    logic [0:15] exp_n, exp_w;
    int free_cnt, exp_slot;
    free_cnt = 0;
    exp_slot = 0;
    for (int i = 15; i >= 0; i--) if (st[i] == 0) begin free_cnt++; exp_slot = i; end
    for (int i = 0; i < 16; i++) begin
      exp_n[i] = model_ready(i, 1'b0);
      exp_w[i] = model_ready(i, 1'b1);
    end
    check_eq("ins_ready", 32'(ins_ready_n), 32'(free_cnt > 0));
    check_eq("ins_ready_waw", 32'(ins_ready_w), 32'(free_cnt > 0));
    if (free_cnt > 0) begin
      check_eq("ins_slot", 32'(ins_slot_n), 32'(exp_slot));
      check_eq("ins_slot_waw", 32'(ins_slot_w), 32'(exp_slot));
    end
    check_eq("ready_mask", 32'(ready_mask_n), 32'(exp_n));
    check_eq("ready_mask_waw", 32'(ready_mask_w), 32'(exp_w));
    check_eq("occupancy", 32'(occ_n), 32'(16 - free_cnt));
    check_eq("occupancy_waw", 32'(occ_w), 32'(16 - free_cnt));
  endtask

  task automatic idle_inputs();
    ins_valid = 1'b0; ins_instr = '0; ins_regwrite = 1'b0; ins_use_rs2 = 1'b0;
    issue_mask = '0; complete_mask = '0; flush = 1'b0;
  endtask

  // Called at a falling edge: drive, advance one rising edge, then check.
  task automatic step(input bit v, input logic [31:0] instr, input bit rw, input bit u2,
                      input logic [0:15] iss, input logic [0:15] cpl, input bit fl);
    ins_valid = v; ins_instr = instr; ins_regwrite = rw; ins_use_rs2 = u2;
    issue_mask = iss; complete_mask = cpl; flush = fl;
    model_update(v, instr, rw, u2, iss, cpl, fl);
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    check_outputs();
  endtask

  function automatic logic [31:0] enc(input int rd, input int rs1, input int rs2);
    return (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(rd) << 7) | 32'h33;
  endfunction

  function automatic logic [0:15] onehot(input int s);
    logic [0:15] m;
    m = '0;
    m[s] = 1'b1;
    return m;
  endfunction

  int s_a, s_b;

  initial begin
    idle_inputs();
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("reset_ins_ready", 32'(ins_ready_n), 32'd1);
    check_eq("reset_ins_slot", 32'(ins_slot_n), 32'd0);
    check_eq("reset_ready_mask", 32'(ready_mask_n), 32'd0);
    check_eq("reset_occupancy", 32'(occ_n), 32'd0);

    // add x3,x1,x2 lands in slot 0 and is ready next cycle
    step(1, enc(3, 1, 2), 1, 1, '0, '0, 0);
    check_eq("first_ready0", 32'(ready_mask_n[0]), 32'd1);
    check_eq("first_occ", 32'(occ_n), 32'd1);

    // RAW chain: reader of x3 waits for slot 0 to complete
    step(1, enc(4, 3, 0), 1, 1, '0, '0, 0);
    check_eq("raw_blocked", 32'(ready_mask_n[1]), 32'd0);
    step(0, '0, 0, 0, onehot(0), '0, 0);
    check_eq("raw_still_blocked", 32'(ready_mask_n[1]), 32'd0);
    step(0, '0, 0, 0, '0, onehot(0), 0);
    check_eq("raw_woken", 32'(ready_mask_n[1]), 32'd1);

    // Bypass: reader of x6 inserted while the x6 writer completes
    s_a = int'(ins_slot_n);
    step(1, enc(6, 0, 0), 1, 0, '0, '0, 0);
    step(0, '0, 0, 0, onehot(s_a), '0, 0);
    s_b = int'(ins_slot_n);
    step(1, enc(7, 6, 0), 1, 0, '0, onehot(s_a), 0);
    check_eq("bypass_ready", 32'(ready_mask_n[s_b]), 32'd1);

    // WAW: second writer of x5 blocked only in the WAW instance
    step(1, enc(5, 0, 0), 1, 0, '0, '0, 0);
    s_b = int'(ins_slot_n);
    step(1, enc(5, 0, 0), 1, 0, '0, '0, 0);
    check_eq("waw_off_ready", 32'(ready_mask_n[s_b]), 32'd1);
    check_eq("waw_on_blocked", 32'(ready_mask_w[s_b]), 32'd0);

    // Flush with 5 occupied slots, then a reader of x1 is independent
    step(0, '0, 0, 0, '0, '0, 1);
    for (int i = 0; i < 5; i++) step(1, enc(1, 0, 0), 1, 0, '0, '0, 0);
    check_eq("pre_flush_occ", 32'(occ_n), 32'd5);
    step(1, enc(2, 0, 0), 1, 0, onehot(0), onehot(0), 1);
    check_eq("flush_occ", 32'(occ_n), 32'd0);
    check_eq("flush_ready_mask", 32'(ready_mask_n), 32'd0);
    step(1, enc(2, 1, 1), 1, 1, '0, '0, 0);
    check_eq("post_flush_ready", 32'(ready_mask_n[0]), 32'd1);

    // Fill every slot; further inserts are ignored, a freed slot reappears next cycle
    step(0, '0, 0, 0, '0, '0, 1);
    for (int i = 0; i < 16; i++) step(1, enc(0, 0, 0), 0, 0, '0, '0, 0);
    check_eq("full_not_ready", 32'(ins_ready_n), 32'd0);
    step(1, enc(0, 0, 0), 0, 0, '0, '0, 0);
    check_eq("full_occ", 32'(occ_n), 32'd16);
    step(0, '0, 0, 0, onehot(7), '0, 0);
    step(1, enc(0, 0, 0), 0, 0, '0, onehot(7), 0);
    check_eq("refill_slot", 32'(ins_slot_n), 32'd7);
    check_eq("refill_ready", 32'(ins_ready_n), 32'd1);

    // Asynchronous reset between edges with 5 slots occupied
    step(0, '0, 0, 0, '0, '0, 1);
    for (int i = 0; i < 5; i++) step(1, enc(1, 0, 0), 1, 0, '0, '0, 0);
    #2 rst = 1'b1;
    #1;
    check_eq("async_rst_occ", 32'(occ_n), 32'd0);
    check_eq("async_rst_ready", 32'(ins_ready_n), 32'd1);
    check_eq("async_rst_slot", 32'(ins_slot_n), 32'd0);
    check_eq("async_rst_mask", 32'(ready_mask_n), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(1, enc(2, 1, 1), 1, 1, '0, '0, 0);
    check_eq("post_rst_ready", 32'(ready_mask_n[0]), 32'd1);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      step(($urandom % 10) < 7, $urandom, ($urandom % 4) != 0, $urandom % 2 == 1,
           16'($urandom & $urandom), 16'($urandom & $urandom), ($urandom % 256) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
